// File: rtl/serial_adder_datapath_pkg.sv
// Shared definitions for the bit-serial adder: default width, FSM encoding
// and the carry helper used by the full-adder cell.
package serial_adder_datapath_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic majority3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_datapath_full_adder.sv
// One-bit combinational full adder used for each serial bit step.
module full_adder
    import serial_adder_datapath_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = majority3(a, b, cin);

endmodule

// File: rtl/serial_adder_datapath.sv
// Bit-serial adder: operands captured on load, one bit summed per enabled
// clock LSB-first, result and final carry held until the next load.
module serial_adder_datapath
    import serial_adder_datapath_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    full_adder u_full_adder (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    // load overrides every state; start only advances the datapath in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (load) begin
            state   <= ST_RUN;
            a_sr    <= a_in;
            b_sr    <= b_in;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (start) begin
                        a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                        b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                        sum     <= {fa_s, sum[WIDTH-1:1]};
                        carry   <= fa_c;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (last_bit) begin
                            cout  <= fa_c;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_IDLE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder_datapath.sv
// Directed bench for the bit-serial adder: latency, pause, reload and
// asynchronous reset behaviour with hand-computed results.
module tb_serial_adder_datapath;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;
    int lat;
    int done_seen;

    serial_adder_datapath #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse load for one edge; returns at the falling edge after the load edge.
    task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic st_during, input logic st_after);
        @(negedge clk);
        load  = 1'b1;
        a_in  = a;
        b_in  = b;
        start = st_during;
        @(negedge clk);
        load  = 1'b0;
        start = st_after;
        a_in  = $urandom_range(0, 255);
        b_in  = $urandom_range(0, 255);
    endtask

    // Counts rising edges until done is seen; -1 if the budget expires.
    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        reset = 1'b0;

        // 0x5A + 0x3C with load and start together
        do_load(8'h5A, 8'h3C, 1'b1, 1'b1);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_sum_clr", 32'(sum), 32'h0);
        wait_done(20, lat);
        check("t1_latency", 32'(lat), 32'd8);
        check("t1_sum", 32'(sum), 32'h96);
        check("t1_cout", 32'(cout), 32'h0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'h0);
        check("t1_idle", 32'(dbg_state), 32'h0);
        repeat (3) @(negedge clk);
        check("t1_hold_sum", 32'(sum), 32'h96);

        // 0xFF + 0x01: carry out
        do_load(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done(20, lat);
        check("t2_latency", 32'(lat), 32'd8);
        check("t2_sum", 32'(sum), 32'h00);
        check("t2_cout", 32'(cout), 32'h1);
        check("t2_busy_at_done", 32'(busy), 32'h0);
        @(negedge clk);
        check("t2_done_pulse", 32'(done), 32'h0);
        check("t2_cout_hold", 32'(cout), 32'h1);

        // 0x0F + 0x01 with a 3-cycle pause after step 4
        do_load(8'h0F, 8'h01, 1'b0, 1'b1);
        check("t3_cout_clr", 32'(cout), 32'h0);
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_busy_pause", 32'(busy), 32'h1);
        check("t3_done_pause", 32'(done), 32'h0);
        start = 1'b1;
        wait_done(20, lat);
        check("t3_latency_rest", 32'(lat), 32'd4);
        check("t3_sum", 32'(sum), 32'h10);
        check("t3_cout", 32'(cout), 32'h0);

        // 0x11 + 0x22 abandoned after 5 steps by a reload of 0x80 + 0x80
        do_load(8'h11, 8'h22, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        do_load(8'h80, 8'h80, 1'b1, 1'b1);
        wait_done(20, lat);
        check("t4_latency", 32'(lat), 32'd8);
        check("t4_sum", 32'(sum), 32'h00);
        check("t4_cout", 32'(cout), 32'h1);

        // asynchronous reset after step 3 of 0x33 + 0x44
        do_load(8'h33, 8'h44, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("t5_sum_partial", 32'(sum), 32'hE0);
        #2 reset = 1'b1;
        #1;
        check("t5_async_sum", 32'(sum), 32'h0);
        check("t5_async_busy", 32'(busy), 32'h0);
        check("t5_async_state", 32'(dbg_state), 32'h0);
        check("t5_async_cout", 32'(cout), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("t5_no_done", 32'(done_seen), 32'd0);
        check("t5_idle", 32'(dbg_state), 32'h0);
        do_load(8'h01, 8'h01, 1'b1, 1'b1);
        wait_done(20, lat);
        check("t5_latency", 32'(lat), 32'd8);
        check("t5_sum", 32'(sum), 32'h02);
        check("t5_cout", 32'(cout), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
